// File: rtl/byte_pack_register_pkg.sv
// Shared definitions for the byte-pack data register: FunSel encodings and
// the width helper for the byte fill counter.
package dr_pkg;

  localparam logic [2:0] DR_LOADS = 3'b000;
  localparam logic [2:0] DR_LOADZ = 3'b001;
  localparam logic [2:0] DR_SHL   = 3'b010;
  localparam logic [2:0] DR_SHR   = 3'b011;
  localparam logic [2:0] DR_CLR   = 3'b100;
  localparam logic [2:0] DR_SWAP  = 3'b101;

  // Bits needed to hold a byte count in the range 0..nbytes inclusive.
  function automatic int count_w(input int nbytes);
    return $clog2(nbytes + 1);
  endfunction

endpackage

// File: rtl/byte_pack_register_if.sv
// Byte-in / word-out bus of the byte-pack register. The master side drives
// bytes and operations; the slave side returns the word and its fill status.
interface byte_pack_register_if #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
);
  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = dr_pkg::count_w(NBYTES);

  logic [BYTE_W-1:0] I;
  logic [2:0]        FunSel;
  logic              E;
  logic              Ready;
  logic [WORD_W-1:0] DROut;
  logic [CNT_W-1:0]  Count;
  logic              Valid;
  logic              Overflow;

  modport master (
    output I, FunSel, E, Ready,
    input  DROut, Count, Valid, Overflow
  );

  modport slave (
    input  I, FunSel, E, Ready,
    output DROut, Count, Valid, Overflow
  );

endinterface

// File: rtl/byte_pack_register_fill_counter.sv
// Saturating byte-fill counter with consume, stall and sticky overflow.
// state   | meaning
// EMPTY   | count == 0
// FILLING | 0 < count < NBYTES
// FULL    | count == NBYTES, valid asserted until consumed
module byte_fill_counter
  import dr_pkg::*;
#(
  parameter int   NBYTES = 4,
  localparam int  CNT_W  = count_w(NBYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e,
  input  logic [2:0]       funsel,
  input  logic             ready,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             fill_ok
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBYTES);

  logic             is_fill;
  logic             consume;
  logic             stall;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  always_comb begin
    is_fill  = e && (funsel == DR_SHL || funsel == DR_SHR);
    consume  = valid && ready;
    stall    = is_fill && valid && !ready;
    fill_ok  = !stall;
    cnt_next = consume ? '0 : count;
    ovf_next = overflow;
    if (e) begin
      case (funsel)
        DR_LOADS, DR_LOADZ: cnt_next = CNT_W'(1);
        DR_SHL, DR_SHR: begin
          if (stall) begin
            cnt_next = count;
            ovf_next = 1'b1;
          end else if (consume) begin
            cnt_next = CNT_W'(1);
          end else if (count != FULL_CNT) begin
            cnt_next = count + CNT_W'(1);
          end
        end
        DR_CLR: begin
          cnt_next = '0;
          ovf_next = 1'b0;
        end
        // SWAP and the unused codes leave the count alone apart from a consume
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count    <= cnt_next;
      valid    <= (cnt_next == FULL_CNT);
      overflow <= ovf_next;
    end
  end

endmodule

// File: rtl/byte_pack_register.sv
// Assembles a WORD_W-bit operand from BYTE_W-bit memory bytes with load,
// shift-fill, clear and byte-swap, handing complete words to the consumer.
module byte_pack_register
  import dr_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input logic                 Clock,
  input logic                 Reset,
  byte_pack_register_if.slave bus
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = count_w(NBYTES);

  logic [WORD_W-1:0] dr_q;
  logic [WORD_W-1:0] swapped;
  logic [CNT_W-1:0]  count;
  logic              valid;
  logic              overflow;
  logic              fill_ok;

  byte_fill_counter #(.NBYTES(NBYTES)) u_fill_counter (
    .clk      (Clock),
    .rst_n    (Reset),
    .e        (bus.E),
    .funsel   (bus.FunSel),
    .ready    (bus.Ready),
    .count    (count),
    .valid    (valid),
    .overflow (overflow),
    .fill_ok  (fill_ok)
  );

  always_comb begin
    swapped = '0;
    for (int k = 0; k < NBYTES; k++) begin
      swapped[k*BYTE_W +: BYTE_W] = dr_q[(NBYTES-1-k)*BYTE_W +: BYTE_W];
    end
  end

  // A blocked fill (word full, consumer not ready) must leave the word intact.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      dr_q <= '0;
    end else if (bus.E) begin
      case (bus.FunSel)
        DR_LOADS: dr_q <= {{(WORD_W-BYTE_W){bus.I[BYTE_W-1]}}, bus.I};
        DR_LOADZ: dr_q <= {{(WORD_W-BYTE_W){1'b0}}, bus.I};
        DR_SHL:   if (fill_ok) dr_q <= {dr_q[WORD_W-BYTE_W-1:0], bus.I};
        DR_SHR:   if (fill_ok) dr_q <= {bus.I, dr_q[WORD_W-1:BYTE_W]};
        DR_CLR:   dr_q <= '0;
        DR_SWAP:  dr_q <= swapped;
        default:  ;
      endcase
    end
  end

  assign bus.DROut    = dr_q;
  assign bus.Count    = count;
  assign bus.Valid    = valid;
  assign bus.Overflow = overflow;

endmodule

// File: tb/tb_byte_pack_register.sv
// Self-checking bench for byte_pack_register (32-bit word, 8-bit bytes):
// directed scenarios plus randomized operations against a byte-array model.
module tb_byte_pack_register;
  import dr_pkg::*;

  logic Clock;
  logic Reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  byte_pack_register_if #(.WORD_W(32), .BYTE_W(8)) bus ();

  byte_pack_register #(.WORD_W(32), .BYTE_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: word kept as an array of bytes, mb[0] is the low byte.
  logic [7:0] mb [4];
  int         mcnt;
  bit         movf;

  function automatic logic [31:0] mword();
    return {mb[3], mb[2], mb[1], mb[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mb[k] = 8'h00;
    mcnt = 0;
    movf = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] fs, input logic en,
                            input logic [7:0] din, input logic rdy);
    bit full_now;
    bit taken;
    full_now = (mcnt == 4);
    taken    = full_now && rdy;
    if (taken) mcnt = 0;
    if (en) begin
      if (fs == DR_LOADS || fs == DR_LOADZ) begin
        mb[0] = din;
        for (int k = 1; k < 4; k++)
          mb[k] = (fs == DR_LOADS && din[7]) ? 8'hFF : 8'h00;
        mcnt = 1;
      end else if (fs == DR_SHL || fs == DR_SHR) begin
        if (full_now && !rdy) begin
          movf = 1'b1;
        end else begin
          if (fs == DR_SHL) begin
            for (int k = 3; k > 0; k--) mb[k] = mb[k-1];
            mb[0] = din;
          end else begin
            for (int k = 0; k < 3; k++) mb[k] = mb[k+1];
            mb[3] = din;
          end
          mcnt = (mcnt < 4) ? mcnt + 1 : 4;
        end
      end else if (fs == DR_CLR) begin
        model_reset();
      end else if (fs == DR_SWAP) begin
        logic [7:0] t [4];
        for (int k = 0; k < 4; k++) t[k] = mb[3-k];
        for (int k = 0; k < 4; k++) mb[k] = t[k];
      end
    end
  endtask

  task automatic do_op(input logic [2:0] fs, input logic en,
                       input logic [7:0] din, input logic rdy);
    bus.FunSel = fs;
    bus.E      = en;
    bus.I      = din;
    bus.Ready  = rdy;
    @(posedge Clock);
    model_step(fs, en, din, rdy);
    #1;
    bus.E     = 1'b0;
    bus.Ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset      = 1'b0;
    bus.E      = 1'b0;
    bus.Ready  = 1'b0;
    bus.I      = 8'h00;
    bus.FunSel = DR_CLR;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    tests_run++;
    if ({bus.DROut, bus.Count, bus.Valid, bus.Overflow} !== 38'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got dr=%h cnt=%0d v=%b o=%b required all zero",
               bus.DROut, bus.Count, bus.Valid, bus.Overflow);
    end
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_load();
    do_op(DR_LOADS, 1'b1, 8'h85, 1'b0);
    tests_run++;
    if (bus.DROut !== 32'hFFFFFF85 || bus.Count !== 3'd1 || bus.Valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL loads: got dr=%h cnt=%0d v=%b required FFFFFF85/1/0",
               bus.DROut, bus.Count, bus.Valid);
    end
    do_op(DR_LOADZ, 1'b1, 8'h85, 1'b0);
    tests_run++;
    if (bus.DROut !== 32'h00000085 || bus.Count !== 3'd1) begin
      tests_failed++;
      $display("FAIL loadz: got dr=%h cnt=%0d required 00000085/1", bus.DROut, bus.Count);
    end
  endtask

  task automatic test_shl_fill();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_op(DR_CLR, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_op(DR_SHL, 1'b1, bytes[k], 1'b0);
      tests_run++;
      if (bus.Count !== 3'(k + 1) || bus.Valid !== (k == 3)) begin
        tests_failed++;
        $display("FAIL shl_count[%0d]: got cnt=%0d v=%b required %0d/%b",
                 k, bus.Count, bus.Valid, k + 1, (k == 3));
      end
    end
    tests_run++;
    if (bus.DROut !== 32'h11223344) begin
      tests_failed++;
      $display("FAIL shl_word: got %h required 11223344", bus.DROut);
    end
  endtask

  task automatic test_overflow();
    do_op(DR_SHL, 1'b1, 8'h55, 1'b0);
    tests_run++;
    if (bus.DROut !== 32'h11223344 || bus.Overflow !== 1'b1 || bus.Count !== 3'd4) begin
      tests_failed++;
      $display("FAIL stall: got dr=%h o=%b cnt=%0d required 11223344/1/4",
               bus.DROut, bus.Overflow, bus.Count);
    end
    do_op(DR_SHL, 1'b0, 8'h66, 1'b1);
    tests_run++;
    if (bus.Valid !== 1'b0 || bus.Count !== 3'd0 || bus.DROut !== 32'h11223344
        || bus.Overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL consume_idle: got v=%b cnt=%0d dr=%h o=%b required 0/0/11223344/1",
               bus.Valid, bus.Count, bus.DROut, bus.Overflow);
    end
    do_op(DR_CLR, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (bus.Overflow !== 1'b0 || bus.DROut !== 32'h0) begin
      tests_failed++;
      $display("FAIL clr_ovf: got o=%b dr=%h required 0/00000000", bus.Overflow, bus.DROut);
    end
  endtask

  task automatic test_shr_swap();
    logic [7:0] bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_op(DR_CLR, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) do_op(DR_SHR, 1'b1, bytes[k], 1'b0);
    tests_run++;
    if (bus.DROut !== 32'hDDCCBBAA || bus.Valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL shr_word: got dr=%h v=%b required DDCCBBAA/1", bus.DROut, bus.Valid);
    end
    do_op(DR_SWAP, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (bus.DROut !== 32'hAABBCCDD || bus.Count !== 3'd4) begin
      tests_failed++;
      $display("FAIL swap: got dr=%h cnt=%0d required AABBCCDD/4", bus.DROut, bus.Count);
    end
  endtask

  task automatic test_consume_fill();
    do_op(DR_SHL, 1'b1, 8'h77, 1'b1);
    tests_run++;
    if (bus.DROut !== 32'hBBCCDD77 || bus.Count !== 3'd1 || bus.Valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL consume_fill: got dr=%h cnt=%0d v=%b required BBCCDD77/1/0",
               bus.DROut, bus.Count, bus.Valid);
    end
  endtask

  task automatic test_async_reset();
    do_op(DR_CLR, 1'b1, 8'h00, 1'b0);
    do_op(DR_SHL, 1'b1, 8'hA1, 1'b0);
    do_op(DR_SHL, 1'b1, 8'hB2, 1'b0);
    tests_run++;
    if (bus.Count !== 3'd2) begin
      tests_failed++;
      $display("FAIL midfill_count: got %0d required 2", bus.Count);
    end
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({bus.DROut, bus.Count, bus.Valid, bus.Overflow} !== 38'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got dr=%h cnt=%0d v=%b o=%b required all zero",
               bus.DROut, bus.Count, bus.Valid, bus.Overflow);
    end
    @(negedge Clock);
    Reset = 1'b1;
    do_op(DR_SHL, 1'b1, 8'h01, 1'b0);
    tests_run++;
    if (bus.DROut !== 32'h00000001 || bus.Count !== 3'd1) begin
      tests_failed++;
      $display("FAIL post_reset_shl: got dr=%h cnt=%0d required 00000001/1",
               bus.DROut, bus.Count);
    end
  endtask

  task automatic test_random();
    logic [2:0] fs;
    logic [3:0] r;
    logic       en;
    logic       rdy;
    logic [7:0] din;
    for (int n = 0; n < 400; n++) begin
      r   = 4'($urandom_range(0, 15));
      fs  = (r < 4'd8) ? (r[0] ? DR_SHL : DR_SHR) : r[2:0];
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) == 0);
      din = 8'($urandom);
      do_op(fs, en, din, rdy);
      tests_run++;
      if (bus.DROut !== mword()) begin
        tests_failed++;
        $display("FAIL rand_word[%0d]: got %h required %h", n, bus.DROut, mword());
      end
      tests_run++;
      if ({bus.Count, bus.Valid, bus.Overflow} !== {3'(mcnt), (mcnt == 4), movf}) begin
        tests_failed++;
        $display("FAIL rand_status[%0d]: got cnt=%0d v=%b o=%b required %0d/%b/%b",
                 n, bus.Count, bus.Valid, bus.Overflow, mcnt, (mcnt == 4), movf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl_fill();
    test_overflow();
    test_shr_swap();
    test_consume_fill();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/byte_pack_register.md
# byte_pack_register

Parametrised successor to the CPU's 8-bit-fed data register. It assembles a `WORD_W`-bit word from `BYTE_W`-bit input bytes using sign-extended load, zero-extended load, shift-left fill and shift-right fill. It also adds a fill counter, a word-valid/ready handshake toward the consumer, a sticky overflow flag, a clear and a byte-swap. It sits between the memory byte port and the ALU/register-file operand path.

## Interface

Parameters:
- `WORD_W`, default 32: width of the assembled word. Must be an integer multiple of `BYTE_W` and at least 2×`BYTE_W`.
- `BYTE_W`, default 8: width of each input byte.
- `NBYTES`, derived as `WORD_W/BYTE_W`: not overridable.

Ports:
- `Clock`, input, 1: the single clock; all state updates on the rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `I`, input, `BYTE_W`: input byte.
- `FunSel`, input, 3: operation select.
- `E`, input, 1: operation enable.
- `Ready`, input, 1: consumer accepts the word while `Valid`=1.
- `DROut`, output, `WORD_W`: assembled word.
- `Count`, output, `$clog2(NBYTES+1)`: number of bytes held, 0..`NBYTES`.
- `Valid`, output, 1: the word is complete (`Count`==`NBYTES`).
- `Overflow`, output, 1: sticky; a fill was attempted while the word was full and not yet consumed.

## Operation

FunSel encoding, executed only when `E`=1:
- `000` LOADS: `DROut` = sign-extended `I`; `Count`=1.
- `001` LOADZ: `DROut` = zero-extended `I`; `Count`=1.
- `010` SHL: `DROut` = {`DROut[WORD_W-BYTE_W-1:0]`, `I`}; `Count`+1, saturating at `NBYTES`.
- `011` SHR: `DROut` = {`I`, `DROut[WORD_W-1:BYTE_W]`}; `Count`+1, saturating at `NBYTES`.
- `100` CLR: `DROut`=0; `Count`=0; `Overflow`=0.
- `101` SWAP: reverse the byte order of `DROut`; `Count` unchanged.
- `110` and `111`: no operation.

Count-derived states:
- EMPTY: `Count`=0.
- FILLING: 0<`Count`<`NBYTES`.
- FULL: `Count`=`NBYTES`; `Valid`=1.

Handshake:
- The word is consumed when `Valid` && `Ready` is true at a rising edge.
- On consume, `Count`→0 and `Valid`→0. `DROut` keeps its value.

Stall:
- A fill is SHL or SHR.
- A fill with `Valid`=1 and `Ready`=0 is blocked: `DROut` and `Count` are unchanged and `Overflow`←1.

Simultaneous events:
- Consume plus fill in the same cycle: the fill executes and `Count`=1.
- Consume plus LOADS/LOADZ: the load executes and `Count`=1.
- Consume plus CLR: the CLR result applies.
- Consume plus SWAP: the swap executes and `Count`=0.
- LOADS, LOADZ, CLR and SWAP always execute regardless of `Valid`.

`E`=0:
- `DROut` holds.
- A consume still takes effect.

## Timing

- Every output is registered. An operation is visible one cycle after the rising edge that samples it.
- `Valid` rises in the same cycle `DROut` receives the `NBYTES`-th byte.
- Reset values: `DROut`=0, `Count`=0, `Valid`=0, `Overflow`=0.
- Reset takes effect immediately on `Reset` falling, independent of `Clock`, including mid-fill and while `Valid`=1.
- The first operation after reset release is sampled on the first rising edge with `Reset`=1.
- There are no combinational paths from inputs to outputs.

## Structure

- Shared package `dr_pkg` holds:
  - the `FunSel` encoding constants: `DR_LOADS`, `DR_LOADZ`, `DR_SHL`, `DR_SHR`, `DR_CLR`, `DR_SWAP`;
  - the count-width helper function.
- One sub-module, `byte_fill_counter`, is natural. It contains the saturating count, the consume/stall logic and `Valid`/`Overflow` generation.
- The data path stays in the top module.

## Test plan

All scenarios use `WORD_W`=32, `BYTE_W`=8.

1. Reset, then LOADS with `I`=0x85 → `DROut`=0xFFFFFF85, `Count`=1, `Valid`=0. LOADZ with 0x85 → `DROut`=0x00000085.
2. CLR, then SHL with 0x11, 0x22, 0x33, 0x44 and `Ready`=0 → `DROut`=0x11223344, `Count`=4, `Valid`=1 after the fourth edge.
3. From scenario 2, SHL with 0x55 and `Ready`=0 → `DROut` stays 0x11223344, `Overflow`=1. Then `Ready`=1 for one cycle → `Valid`=0, `Count`=0, `DROut` unchanged. Then CLR → `Overflow`=0.
4. CLR, SHR with 0xAA, 0xBB, 0xCC, 0xDD → `DROut`=0xDDCCBBAA, `Valid`=1. SWAP → 0xAABBCCDD, `Count` stays 4.
5. FULL with `Ready`=1 and SHL 0x77 in the same cycle → `Count`=1, `Valid`=0, `DROut`=0xBBCCDD77 (continuing from scenario 4).
6. Mid-fill with `Count`=2, drive `Reset` low between clock edges → `DROut`, `Count`, `Valid` and `Overflow` all 0 immediately. Release reset and SHL 0x01 → `Count`=1, `DROut`=0x00000001.
